i2c_init_sequencer: RTL and testbench
=====================================

Name: i2c_init_sequencer

Overview:
- Sequences the shared i2c_controller through a fixed table of peripheral register writes, such as audio-codec power-up configuration, after a single start pulse.
- Sits between the top-level control logic and i2c_controller.
  - Drives the controller's enable/mode/address/byte inputs.
  - Watches its completion and NACK status.
- Handles inter-command gaps, NACK retries and hung-bus timeouts.
- Reports done/error to the top level.

Parameters:
- NUM_CMDS, 8: number of table entries issued, 1..16.
- PERIPH_ADDR, 7'h1A: 7-bit target address used for every command.
- RETRY_MAX, 3: retries per entry after a NACK or timeout before failing.
- GAP_CYCLES, 16: idle clk cycles between transactions, >=1.
- TIMEOUT_CYCLES, 1024: max clk cycles spent waiting for i2c_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin sequence; sampled only in IDLE, DONE or FAIL.
- busy  out  1  high in any state other than IDLE/DONE/FAIL.
- done  out  1  high while in DONE.
- error  out  1  high while in FAIL.
- cmd_index  out  4  current table entry.
- i2c_enable  out  1  one-cycle transaction request to i2c_controller.
- i2c_mode  out  1  0 = write; 1 = read (readback only).
- i2c_periph_addr  out  7  equals PERIPH_ADDR.
- i2c_reg  out  8  register address byte.
- i2c_data  out  8  data byte.
- i2c_done  in  1  one-cycle pulse at end of transaction.
- i2c_ack_err  in  1  qualified by i2c_done; 1 = NACK seen.
- i2c_rdata  in  8  read byte; used only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, error, i2c_enable, i2c_mode = 0.
  - cmd_index, i2c_reg, i2c_data, retry and gap/timeout counters = 0.
  - Reset mid-transaction drops i2c_enable immediately and does not resume.
- States: IDLE, LOAD, ISSUE, WAIT, GAP, NEXT, DONE, FAIL.
- IDLE/DONE/FAIL:
  - start=1 -> LOAD, with cmd_index=0, retries=0, done/error cleared on the next edge.
  - start is ignored while busy.
- LOAD (1 cycle): register the table entry at cmd_index into i2c_reg/i2c_data -> ISSUE.
- ISSUE (1 cycle):
  - i2c_enable=1, i2c_mode=0 for exactly this cycle.
  - Clear timeout counter -> WAIT.
- WAIT:
  - i2c_done=1 and i2c_ack_err=0 -> GAP with success.
  - i2c_done=1 and i2c_ack_err=1, or timeout counter reaches TIMEOUT_CYCLES-1:
    - retries<RETRY_MAX -> retries+1, GAP with retry.
    - else -> FAIL.
  - If i2c_done coincides with the timeout terminal count, i2c_done takes priority.
- GAP:
  - Counts GAP_CYCLES cycles.
  - Retry path -> ISSUE with the same entry.
  - Success path -> NEXT.
- NEXT:
  - cmd_index==NUM_CMDS-1 -> DONE.
  - Else cmd_index+1, retries=0 -> LOAD.
- FAIL: cmd_index holds the failing entry.
- Table contents come from the sub-module.
  - Entries >= NUM_CMDS are never read.
  - cmd_index never wraps.
- Latency:
  - start to the first i2c_enable is 2 cycles (LOAD, ISSUE).
  - i2c_done of entry k to i2c_enable of entry k+1 is GAP_CYCLES+2 cycles.

Optional Feature:
- Macro I2C_INIT_SEQ_READBACK_EN.
- Defined:
  - After each successful write, GAP leads to new states RD_ISSUE then RD_WAIT.
  - RD_ISSUE pulses i2c_enable with i2c_mode=1 and the same i2c_reg.
  - On i2c_done, i2c_rdata is compared with i2c_data.
    - Mismatch counts as a failure and uses the same retry/FAIL rules, restarting from the write.
    - Match -> NEXT.
- Undefined:
  - Readback states are absent.
  - i2c_rdata is unused and i2c_mode stays 0.

Decomposition:
- Shared package i2c_pkg holds:
  - State encoding (localparams).
  - I2C_MODE_WRITE=0 and I2C_MODE_READ=1.
  - Default codec address 7'h1A.
- Sub-module i2c_init_rom: combinational index[3:0] -> {reg[7:0], data[7:0]}, with the table as a case statement.

Test Plan:
- Reset mid-WAIT (drive reset=0 while busy) -> all outputs 0 immediately; state IDLE after reset=1; no i2c_enable pulse until a new start.
- NUM_CMDS=3, model acks all -> exactly 3 i2c_enable pulses with i2c_reg/i2c_data matching ROM entries 0..2 and i2c_periph_addr=7'h1A; 18-cycle spacing after each i2c_done; done=1 with cmd_index=2.
- NACK on entry 1 for the first 2 attempts -> entry 1 issued 3 times, entry 2 follows; done=1, error=0.
- Permanent NACK on entry 0 with RETRY_MAX=3 -> 4 pulses then error=1, cmd_index=0, busy=0; a new start clears error and restarts.
- Model never returns i2c_done, TIMEOUT_CYCLES=64 -> reissue every 64+GAP cycles; FAIL after 4 attempts.
- Readback enabled: model returns data^8'h01 once on entry 0 -> write+read repeated; the second comparison passes and the sequence completes.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, transfer modes, default codec address.
// The readback states exist only when I2C_INIT_SEQ_READBACK_EN is defined.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_LOAD     = 4'd1;
    localparam logic [3:0] ST_ISSUE    = 4'd2;
    localparam logic [3:0] ST_WAIT     = 4'd3;
    localparam logic [3:0] ST_GAP      = 4'd4;
    localparam logic [3:0] ST_NEXT     = 4'd5;
    localparam logic [3:0] ST_DONE     = 4'd6;
    localparam logic [3:0] ST_FAIL     = 4'd7;
    localparam logic [3:0] ST_RD_ISSUE = 4'd8;
    localparam logic [3:0] ST_RD_WAIT  = 4'd9;

    localparam logic       I2C_MODE_WRITE = 1'b0;
    localparam logic       I2C_MODE_READ  = 1'b1;
    localparam logic [6:0] I2C_CODEC_ADDR = 7'h1A;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_LOAD     = ST_LOAD,
        S_ISSUE    = ST_ISSUE,
        S_WAIT     = ST_WAIT,
        S_GAP      = ST_GAP,
        S_NEXT     = ST_NEXT,
        S_DONE     = ST_DONE,
`ifdef I2C_INIT_SEQ_READBACK_EN
        S_RD_ISSUE = ST_RD_ISSUE,
        S_RD_WAIT  = ST_RD_WAIT,
`endif
        S_FAIL     = ST_FAIL
    } state_t;

endpackage

// File: rtl/i2c_init_rom.sv
// Codec power-up register table: index -> {register address, data byte}.
module i2c_init_rom
    import i2c_pkg::*;
(
    input  logic [3:0] i_index,
    output logic [7:0] o_reg,
    output logic [7:0] o_data
);

    always_comb begin
        case (i_index)
            4'd0:    {o_reg, o_data} = 16'h1E00;
            4'd1:    {o_reg, o_data} = 16'h0C10;
            4'd2:    {o_reg, o_data} = 16'h0E02;
            4'd3:    {o_reg, o_data} = 16'h1000;
            4'd4:    {o_reg, o_data} = 16'h0812;
            4'd5:    {o_reg, o_data} = 16'h0A06;
            4'd6:    {o_reg, o_data} = 16'h0017;
            4'd7:    {o_reg, o_data} = 16'h0217;
            4'd8:    {o_reg, o_data} = 16'h0479;
            4'd9:    {o_reg, o_data} = 16'h0679;
            4'd10:   {o_reg, o_data} = 16'h1201;
            default: {o_reg, o_data} = 16'h0000;
        endcase
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks i2c_controller through the init ROM with gaps, NACK/timeout retries and done/error reporting.
// Define I2C_INIT_SEQ_READBACK_EN to read back and verify every written register.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter int         NUM_CMDS       = 8,
    parameter logic [6:0] PERIPH_ADDR    = I2C_CODEC_ADDR,
    parameter int         RETRY_MAX      = 3,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] cmd_index,
    output logic       i2c_enable,
    output logic       i2c_mode,
    output logic [6:0] i2c_periph_addr,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_data,
    input  logic       i2c_done,
    input  logic       i2c_ack_err,
    input  logic [7:0] i2c_rdata
);

    localparam int CNT_W = $clog2((TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES) + 1;
    localparam int RTY_W = $clog2(RETRY_MAX + 1) + 1;

    state_t             r_state, w_state_nx;
    logic [3:0]         r_cmd_index, w_idx_nx;
    logic [7:0]         r_reg, w_reg_nx, r_data, w_data_nx;
    logic [RTY_W-1:0]   r_retry, w_retry_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic               r_gap_retry, w_gap_retry_nx;
    logic [7:0]         w_rom_reg, w_rom_data;
    logic               w_ok, w_bad;

    i2c_init_rom u_rom (
        .i_index (r_cmd_index),
        .o_reg   (w_rom_reg),
        .o_data  (w_rom_data)
    );

`ifndef I2C_INIT_SEQ_READBACK_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^i2c_rdata;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd_index <= '0;
            r_reg       <= '0;
            r_data      <= '0;
            r_retry     <= '0;
            r_cnt       <= '0;
            r_gap_retry <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_index <= w_idx_nx;
            r_reg       <= w_reg_nx;
            r_data      <= w_data_nx;
            r_retry     <= w_retry_nx;
            r_cnt       <= w_cnt_nx;
            r_gap_retry <= w_gap_retry_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_cmd_index;
        w_reg_nx       = r_reg;
        w_data_nx      = r_data;
        w_retry_nx     = r_retry;
        w_cnt_nx       = r_cnt;
        w_gap_retry_nx = r_gap_retry;
        w_ok           = i2c_done && !i2c_ack_err;
`ifdef I2C_INIT_SEQ_READBACK_EN
        if (r_state == S_RD_WAIT)
            w_ok = w_ok && (i2c_rdata == r_data);
`endif
        // i2c_done outranks a timeout landing on the same cycle
        w_bad          = !w_ok && (i2c_done || (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)));

        busy            = 1'b1;
        done            = 1'b0;
        error           = 1'b0;
        i2c_enable      = 1'b0;
        i2c_mode        = I2C_MODE_WRITE;
        i2c_periph_addr = PERIPH_ADDR;
        i2c_reg         = r_reg;
        i2c_data        = r_data;
        cmd_index       = r_cmd_index;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                busy  = 1'b0;
                done  = (r_state == S_DONE);
                error = (r_state == S_FAIL);
                if (start) begin
                    w_state_nx = S_LOAD;
                    w_idx_nx   = '0;
                    w_retry_nx = '0;
                end
            end
            S_LOAD: begin
                w_reg_nx   = w_rom_reg;
                w_data_nx  = w_rom_data;
                w_state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                i2c_enable = 1'b1;
                w_cnt_nx   = '0;
                w_state_nx = S_WAIT;
            end
`ifdef I2C_INIT_SEQ_READBACK_EN
            S_RD_ISSUE: begin
                i2c_enable = 1'b1;
                i2c_mode   = I2C_MODE_READ;
                w_cnt_nx   = '0;
                w_state_nx = S_RD_WAIT;
            end
            S_WAIT, S_RD_WAIT: begin
`else
            S_WAIT: begin
`endif
                w_cnt_nx = r_cnt + 1'b1;
                // The completing cycle is the first gap cycle, so GAP starts its count at 1
                if (w_ok) begin
                    w_cnt_nx       = CNT_W'(1);
                    w_gap_retry_nx = 1'b0;
                    w_state_nx     = (r_state == S_WAIT) ? S_GAP : S_NEXT;
                end else if (w_bad) begin
                    w_cnt_nx = CNT_W'(1);
                    if (r_retry < RTY_W'(RETRY_MAX)) begin
                        w_retry_nx     = r_retry + 1'b1;
                        w_gap_retry_nx = 1'b1;
                        w_state_nx     = S_GAP;
                    end else begin
                        w_state_nx = S_FAIL;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt >= CNT_W'(GAP_CYCLES - 1)) begin
                    w_cnt_nx = '0;
                    if (r_gap_retry)
                        w_state_nx = S_ISSUE;
                    else
`ifdef I2C_INIT_SEQ_READBACK_EN
                        w_state_nx = S_RD_ISSUE;
`else
                        w_state_nx = S_NEXT;
`endif
                end
            end
            S_NEXT: begin
                if (r_cmd_index == 4'(NUM_CMDS - 1)) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_idx_nx   = r_cmd_index + 1'b1;
                    w_retry_nx = '0;
                    w_state_nx = S_LOAD;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Self-checking bench: table and random NACK scenarios against a behavioural controller model.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;

    localparam int N    = 3;
    localparam int RMAX = 3;
    localparam int GAP  = 16;
    localparam int TMO  = 64;
`ifdef I2C_INIT_SEQ_READBACK_EN
    localparam int WR_ACK_LAT = GAP;
`else
    localparam int WR_ACK_LAT = GAP + 2;
`endif

    logic       clk = 1'b0;
    logic       reset, start, busy, done, error;
    logic [3:0] cmd_index;
    logic       i2c_enable, i2c_mode, i2c_done, i2c_ack_err;
    logic [6:0] i2c_periph_addr;
    logic [7:0] i2c_reg, i2c_data, i2c_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] rom_ref [16];
    int exp_q[$];

    typedef struct {
        int nk0, nk1, nk2;
        bit hang;
        bit rbbad;
        int pulses;
        bit edone;
        bit eerr;
        int eidx;
    } vec_t;

    vec_t vecs[$];

    i2c_init_sequencer #(
        .NUM_CMDS(N), .PERIPH_ADDR(7'h1A), .RETRY_MAX(RMAX),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .cmd_index(cmd_index), .i2c_enable(i2c_enable), .i2c_mode(i2c_mode),
        .i2c_periph_addr(i2c_periph_addr), .i2c_reg(i2c_reg), .i2c_data(i2c_data),
        .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err), .i2c_rdata(i2c_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Each entry is attempted once plus once per failure; more than RMAX failures ends the run there.
    task automatic build_model(input vec_t v, output int pulses, output bit m_done,
                               output bit m_err, output int m_idx);
        int nk[3];
        int fails;
        nk[0] = v.nk0; nk[1] = v.nk1; nk[2] = v.nk2;
        exp_q.delete();
        m_done = 1'b1; m_err = 1'b0; m_idx = N - 1;
        for (int e = 0; e < N; e++) begin
            fails = v.hang ? RMAX + 1 : nk[e] + ((v.rbbad && e == 0) ? 1 : 0);
            if (fails > RMAX) begin
                for (int k = 0; k <= RMAX; k++) exp_q.push_back(e);
                m_done = 1'b0; m_err = 1'b1; m_idx = e;
                break;
            end
            for (int k = 0; k <= fails; k++) exp_q.push_back(e);
        end
        pulses = exp_q.size();
    endtask

    task automatic respond(input bit nack, input logic [7:0] rd, output int lat_ref);
        int lat;
        lat = $urandom_range(1, 8);
        @(negedge clk);
        chk("enable_one_cycle", int'(i2c_enable), 0);
        repeat (lat - 1) @(negedge clk);
        i2c_done = 1'b1; i2c_ack_err = nack; i2c_rdata = rd; lat_ref = cyc;
        @(negedge clk);
        i2c_done = 1'b0; i2c_ack_err = 1'($urandom); i2c_rdata = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int nk[3];
        int att[3];
        int mp, midx, nw, bound, prev, exp_lat, lat_ref, e;
        bit md, me, nack, bad_pending, fin;
        build_model(v, mp, md, me, midx);
        nk[0] = v.nk0; nk[1] = v.nk1; nk[2] = v.nk2;
        att = '{0, 0, 0};
        bad_pending = v.rbbad;
        @(negedge clk); start = 1'b1; lat_ref = cyc; prev = 0;
        @(negedge clk); start = 1'b0;
        nw = 0; fin = 1'b0;
        while (!fin) begin
            bound = 0;
            while (!i2c_enable && busy && bound < 2000) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 2000) begin
                checks++; errors++;
                $display("FAIL %s.wait_bound: no enable or completion within 2000 cycles", nm);
                fin = 1'b1;
            end else if (!i2c_enable) begin
                fin = 1'b1;
            end else begin
                case (prev)
                    0:       exp_lat = 2;
                    1:       exp_lat = WR_ACK_LAT;
                    2:       exp_lat = GAP;
                    3:       exp_lat = TMO + GAP;
                    default: exp_lat = 3;
                endcase
                e = int'(cmd_index);
                chk({nm, ".lat"}, cyc - lat_ref, exp_lat);
                chk({nm, ".addr"}, int'(i2c_periph_addr), 'h1A);
                chk({nm, ".reg"}, int'(i2c_reg), int'(rom_ref[e][15:8]));
                chk({nm, ".data"}, int'(i2c_data), int'(rom_ref[e][7:0]));
                if (e >= N) e = N - 1;
`ifdef I2C_INIT_SEQ_READBACK_EN
                if (i2c_mode) begin
                    nack = bad_pending && (e == 0);
                    if (nack) bad_pending = 1'b0;
                    respond(1'b0, i2c_data ^ {7'd0, nack}, lat_ref);
                    prev = nack ? 2 : 4;
                end else begin
`else
                begin
`endif
                    chk({nm, ".mode"}, int'(i2c_mode), 0);
                    chk({nm, ".idx"}, e, (nw < exp_q.size()) ? exp_q[nw] : 99);
                    if (nw == 0) begin
                        chk({nm, ".done_cleared"}, int'(done), 0);
                        chk({nm, ".error_cleared"}, int'(error), 0);
                    end
                    nw++;
                    if (v.hang) begin
                        lat_ref = cyc; prev = 3;
                        @(negedge clk);
                        chk({nm, ".enable_one_cycle"}, int'(i2c_enable), 0);
                    end else begin
                        nack = att[e] < nk[e];
                        att[e]++;
                        respond(nack, 8'h00, lat_ref);
                        prev = nack ? 2 : 1;
                    end
                end
            end
        end
        chk({nm, ".pulses"}, nw, v.pulses);
        chk({nm, ".done"}, int'(done), int'(v.edone));
        chk({nm, ".error"}, int'(error), int'(v.eerr));
        chk({nm, ".cmd_index"}, int'(cmd_index), v.eidx);
        chk({nm, ".busy"}, int'(busy), 0);
    endtask

    initial begin
        int bound, seen;
        vec_t v;
        rom_ref = '{16'h1E00, 16'h0C10, 16'h0E02, 16'h1000, 16'h0812, 16'h0A06, 16'h0017, 16'h0217,
                    16'h0479, 16'h0679, 16'h1201, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        //          nk0 nk1 nk2 hang rbbad pulses done err idx
        vecs.push_back('{0, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 2});
        vecs.push_back('{0, 2, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 2});
        vecs.push_back('{9, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 0});
        vecs.push_back('{0, 0, 3, 1'b0, 1'b0, 6, 1'b1, 1'b0, 2});
        vecs.push_back('{0, 1, 4, 1'b0, 1'b0, 7, 1'b0, 1'b1, 2});
        vecs.push_back('{0, 0, 0, 1'b1, 1'b0, 4, 1'b0, 1'b1, 0});
        vecs.push_back('{1, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 2});
`ifdef I2C_INIT_SEQ_READBACK_EN
        vecs.push_back('{0, 0, 0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 2});
`endif

        reset = 1'b0; start = 1'b0; i2c_done = 1'b0; i2c_ack_err = 1'b0; i2c_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.error", int'(error), 0);
        chk("rst.enable", int'(i2c_enable), 0);
        chk("rst.mode", int'(i2c_mode), 0);
        chk("rst.cmd_index", int'(cmd_index), 0);
        chk("rst.reg_data", int'({i2c_reg, i2c_data}), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            v = '{0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
            v.nk0 = $urandom_range(0, 4);
            v.nk1 = $urandom_range(0, 4);
            v.nk2 = $urandom_range(0, 4);
            build_model(v, v.pulses, v.edone, v.eerr, v.eidx);
            run_vec(v, $sformatf("rnd%0d", i));
            repeat (2) @(negedge clk);
        end

        // Start while busy is ignored; reset during WAIT clears everything at once
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bound = 0;
        while (!i2c_enable && bound < 50) begin
            @(negedge clk);
            bound++;
        end
        chk("midrst.first_enable", int'(i2c_enable), 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (i2c_enable) seen++;
        end
        chk("busy_start.enables", seen, 0);
        chk("busy_start.busy", int'(busy), 1);
        chk("busy_start.cmd_index", int'(cmd_index), 0);
        reset = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done_error", int'({done, error}), 0);
        chk("midrst.enable", int'(i2c_enable), 0);
        chk("midrst.mode", int'(i2c_mode), 0);
        chk("midrst.cmd_index", int'(cmd_index), 0);
        chk("midrst.reg_data", int'({i2c_reg, i2c_data}), 0);
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (i2c_enable || busy || done || error) seen++;
        end
        chk("midrst.stays_idle", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
